// File: rtl/dlc_fault_map_collector_if.sv
// Bus between dlc_fault_map_collector, the Diagnostic_loop_chains (DLC)
// row-response port and the eNVM fault-map write port.
// master: the collector. slave: the DLC / eNVM side.
interface dlc_fault_map_collector_if #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
);
  // DLC request / response
  logic                     detection_en;
  logic [ADDR_WIDTH-1:0]    detection_addr;
  logic                     row_fault_detection;
  logic                     single_pe_detection;
  logic [SYSTOLIC_SIZE-1:0] column_fault_detection;
  // eNVM write port
  logic                     map_valid;
  logic                     map_ready;
  logic [ADDR_WIDTH-1:0]    map_addr;
  logic [SYSTOLIC_SIZE-1:0] fault_pattern;

  modport master (
    output detection_en, detection_addr, map_valid, map_addr, fault_pattern,
    input  row_fault_detection, single_pe_detection, column_fault_detection, map_ready
  );

  modport slave (
    input  detection_en, detection_addr, map_valid, map_addr, fault_pattern,
    output row_fault_detection, single_pe_detection, column_fault_detection, map_ready
  );
endinterface

// File: rtl/dlc_fault_map_collector.sv
// dlc_fault_map_collector
// Walks the DLC result one row at a time after an LBIST diagnosis pass.
// It decodes each row response into a faulty-PE bitmap and writes it to the
// eNVM fault-map store over a valid/ready port.
// Optional build macro: FAULT_MAP_STATS_EN adds faulty-row and faulty-PE
// counters. When the macro is not defined, both count ports are tied to zero.
module dlc_fault_map_collector #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  dlc_fault_map_collector_if.master link,
  output logic                    busy,
  output logic                    done,
  output logic                    inconsistent,
  output logic [ADDR_WIDTH:0]     faulty_row_count,
  output logic [2*ADDR_WIDTH:0]   faulty_pe_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [ADDR_WIDTH-1:0]    LAST_ROW = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
  localparam logic [SYSTOLIC_SIZE-1:0] ALL_ONES = {SYSTOLIC_SIZE{1'b1}};
  localparam logic [SYSTOLIC_SIZE-1:0] NO_BITS  = {SYSTOLIC_SIZE{1'b0}};

  logic [2:0]               state_r;
  logic [2:0]               state_nxt_s;
  logic [ADDR_WIDTH-1:0]    row_r;
  logic [ADDR_WIDTH-1:0]    row_nxt_s;
  logic                     det_en_r;
  logic [ADDR_WIDTH-1:0]    det_addr_r;
  logic                     map_valid_r;
  logic [ADDR_WIDTH-1:0]    map_addr_r;
  logic [SYSTOLIC_SIZE-1:0] pattern_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     incons_r;
  logic [SYSTOLIC_SIZE-1:0] decoded_s;
  logic                     decode_incons_s;
  logic                     handshake_s;
  logic                     launch_s;

  // map_valid_r mirrors the EMIT state. The handshake therefore depends only
  // on the state register and map_ready.
  assign handshake_s = (state_r == S_EMIT) && link.map_ready;
  assign launch_s    = (state_r == S_IDLE) && start;

  // Decode one DLC row response into a faulty-PE bitmap.
  // A row fault that names no column cannot be localised, so the whole row
  // is retired and the response is flagged as inconsistent.
  always_comb begin
    decoded_s       = NO_BITS;
    decode_incons_s = 1'b0;
    if (!link.row_fault_detection) begin
      decoded_s = NO_BITS;
    end else if (link.column_fault_detection == NO_BITS) begin
      decoded_s       = ALL_ONES;
      decode_incons_s = 1'b1;
    end else if (link.single_pe_detection) begin
      decoded_s = link.column_fault_detection;
    end else begin
      decoded_s = ALL_ONES;
    end
  end

  // Next state and next row for the collection sequencer.
  always_comb begin
    state_nxt_s = state_r;
    row_nxt_s   = row_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = S_REQ;
          row_nxt_s   = {ADDR_WIDTH{1'b0}};
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_REQ:  state_nxt_s = S_WAIT;
      S_WAIT: state_nxt_s = S_EMIT;
      S_EMIT: begin
        if (handshake_s) begin
          if (row_r == LAST_ROW) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_REQ;
            row_nxt_s   = row_r + ADDR_WIDTH'(1);
          end
        end else begin
          state_nxt_s = S_EMIT;
        end
      end
      S_DONE: state_nxt_s = S_IDLE;
      default: begin
        state_nxt_s = S_IDLE;
        row_nxt_s   = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  // Sequencer state plus registered outputs.
  // The output registers are decoded from the next state, so each output
  // lines up with the state it belongs to without a combinational output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      row_r       <= {ADDR_WIDTH{1'b0}};
      det_en_r    <= 1'b0;
      det_addr_r  <= {ADDR_WIDTH{1'b0}};
      map_valid_r <= 1'b0;
      map_addr_r  <= {ADDR_WIDTH{1'b0}};
      pattern_r   <= NO_BITS;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      row_r       <= row_nxt_s;
      det_en_r    <= (state_nxt_s == S_REQ);
      det_addr_r  <= row_nxt_s;
      map_valid_r <= (state_nxt_s == S_EMIT);
      busy_r      <= (state_nxt_s != S_IDLE);
      done_r      <= (state_nxt_s == S_DONE);
      if (state_r == S_WAIT) begin
        map_addr_r <= row_r;
        pattern_r  <= decoded_s;
      end else begin
        map_addr_r <= map_addr_r;
        pattern_r  <= pattern_r;
      end
    end
  end

  // Sticky inconsistency flag: cleared by a fresh collection, set by any row
  // whose fault report named no column.
  always_ff @(posedge clk) begin
    if (rst) begin
      incons_r <= 1'b0;
    end else if (launch_s) begin
      incons_r <= 1'b0;
    end else if ((state_r == S_WAIT) && decode_incons_s) begin
      incons_r <= 1'b1;
    end else begin
      incons_r <= incons_r;
    end
  end

  assign link.detection_en   = det_en_r;
  assign link.detection_addr = det_addr_r;
  assign link.map_valid      = map_valid_r;
  assign link.map_addr       = map_addr_r;
  assign link.fault_pattern  = pattern_r;
  assign busy                = busy_r;
  assign done                = done_r;
  assign inconsistent        = incons_r;

`ifdef FAULT_MAP_STATS_EN
  logic [ADDR_WIDTH:0]   row_cnt_r;
  logic [2*ADDR_WIDTH:0] pe_cnt_r;

  function automatic logic [2*ADDR_WIDTH:0] popcount(input logic [SYSTOLIC_SIZE-1:0] v);
    logic [2*ADDR_WIDTH:0] cnt;
    cnt = {(2*ADDR_WIDTH+1){1'b0}};
    for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
      cnt = cnt + {{(2*ADDR_WIDTH){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  // Fault statistics: these are accumulated on accepted words only. The
  // totals are kept after done until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt_r <= {(ADDR_WIDTH+1){1'b0}};
      pe_cnt_r  <= {(2*ADDR_WIDTH+1){1'b0}};
    end else if (launch_s) begin
      row_cnt_r <= {(ADDR_WIDTH+1){1'b0}};
      pe_cnt_r  <= {(2*ADDR_WIDTH+1){1'b0}};
    end else if (handshake_s) begin
      if (pattern_r != NO_BITS) begin
        row_cnt_r <= row_cnt_r + (ADDR_WIDTH+1)'(1);
      end else begin
        row_cnt_r <= row_cnt_r;
      end
      pe_cnt_r <= pe_cnt_r + popcount(pattern_r);
    end else begin
      row_cnt_r <= row_cnt_r;
      pe_cnt_r  <= pe_cnt_r;
    end
  end

  assign faulty_row_count = row_cnt_r;
  assign faulty_pe_count  = pe_cnt_r;
`else
  assign faulty_row_count = {(ADDR_WIDTH+1){1'b0}};
  assign faulty_pe_count  = {(2*ADDR_WIDTH+1){1'b0}};
`endif

endmodule

// File: tb/tb_dlc_fault_map_collector.sv
// Directed testbench for dlc_fault_map_collector.
// Each expected value below was worked out by hand from the decode rules and
// the 3-cycles-per-row timing.
module tb_dlc_fault_map_collector;
  localparam int SS = 8;
  localparam int AW = 3;
`ifdef FAULT_MAP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic inconsistent;
  logic [AW:0]   faulty_row_count;
  logic [2*AW:0] faulty_pe_count;

  dlc_fault_map_collector_if #(.SYSTOLIC_SIZE(SS), .ADDR_WIDTH(AW)) link ();

  dlc_fault_map_collector #(.SYSTOLIC_SIZE(SS), .ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .link             (link),
    .busy             (busy),
    .done             (done),
    .inconsistent     (inconsistent),
    .faulty_row_count (faulty_row_count),
    .faulty_pe_count  (faulty_pe_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DLC response table per row, and the words expected and received
  logic          rf    [SS];
  logic          sp    [SS];
  logic [SS-1:0] col   [SS];
  logic [SS-1:0] exp_w [SS];
  logic [SS-1:0] got_w [SS];
  int stall_row;
  int stall_len;
  int mid_start_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_tables();
    for (int i = 0; i < SS; i++) begin
      rf[i] = 1'b0; sp[i] = 1'b0; col[i] = '0; exp_w[i] = '0; got_w[i] = 'x;
    end
    stall_row = -1; stall_len = 0; mid_start_cyc = -1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_det_en"},   {31'd0, link.detection_en}, 32'd0);
    check({tag, "_det_addr"}, {29'd0, link.detection_addr}, 32'd0);
    check({tag, "_valid"},    {31'd0, link.map_valid}, 32'd0);
    check({tag, "_addr"},     {29'd0, link.map_addr}, 32'd0);
    check({tag, "_pattern"},  {24'd0, link.fault_pattern}, 32'd0);
    check({tag, "_busy"},     {31'd0, busy}, 32'd0);
    check({tag, "_done"},     {31'd0, done}, 32'd0);
    check({tag, "_incons"},   {31'd0, inconsistent}, 32'd0);
    check({tag, "_rows"},     {28'd0, faulty_row_count}, 32'd0);
    check({tag, "_pes"},      {25'd0, faulty_pe_count}, 32'd0);
  endtask

  // One full collection: the start pulse goes in cycle 0, then the task
  // plays the DLC and the eNVM cycle by cycle. The cycle count is the state
  // seen at each falling edge.
  task automatic run(input string tag, input int exp_done, input bit exp_incons,
                     input int exp_rows, input int exp_pes);
    int cyc = 0;
    int next_row = 0;
    int got_n = 0;
    int done_cyc = -1;
    int stall_left = stall_len;
    bit prev_det = 1'b0;
    bit overlap = 1'b0;
    bit addr_bad = 1'b0;
    bit stable_bad = 1'b0;
    bit incons_at_done = 1'b0;
    logic [SS-1:0] held_p = '0;
    logic [AW-1:0] held_a = '0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 80 && done_cyc < 0; k++) begin
      @(negedge clk);
      cyc++;
      start = (cyc == mid_start_cyc);
      if (link.detection_en && link.map_valid) overlap = 1'b1;
      if (link.detection_en) begin
        if (int'(link.detection_addr) != next_row) addr_bad = 1'b1;
        next_row++;
        link.row_fault_detection    = rf[link.detection_addr];
        link.single_pe_detection    = sp[link.detection_addr];
        link.column_fault_detection = col[link.detection_addr];
      end else if (!prev_det) begin
        // outside the response window, drive deliberately misleading values
        link.row_fault_detection    = 1'b1;
        link.single_pe_detection    = 1'b0;
        link.column_fault_detection = 8'hA5;
      end
      prev_det = link.detection_en;
      if (link.map_valid) begin
        if (stall_left > 0 && int'(link.map_addr) == stall_row) begin
          if (stall_left == stall_len) begin
            held_p = link.fault_pattern;
            held_a = link.map_addr;
          end else if (link.fault_pattern !== held_p || link.map_addr !== held_a) begin
            stable_bad = 1'b1;
          end
          link.map_ready = 1'b0;
          stall_left--;
        end else begin
          if (stall_len > 0 && int'(link.map_addr) == stall_row &&
              (link.fault_pattern !== held_p || link.map_addr !== held_a)) stable_bad = 1'b1;
          link.map_ready = 1'b1;
          if (int'(link.map_addr) != got_n) addr_bad = 1'b1;
          got_w[link.map_addr] = link.fault_pattern;
          got_n++;
        end
      end else begin
        link.map_ready = 1'b1;
      end
      if (done) begin
        done_cyc = cyc;
        incons_at_done = inconsistent;
      end
    end
    check({tag, "_done_cycle"}, done_cyc, exp_done);
    check({tag, "_words"}, got_n, SS);
    check({tag, "_addr_order"}, {31'd0, addr_bad}, 32'd0);
    check({tag, "_det_during_valid"}, {31'd0, overlap}, 32'd0);
    check({tag, "_stall_stable"}, {31'd0, stable_bad}, 32'd0);
    check({tag, "_incons_at_done"}, {31'd0, incons_at_done}, {31'd0, exp_incons});
    for (int i = 0; i < SS; i++) begin
      check($sformatf("%s_word%0d", tag, i), {24'd0, got_w[i]}, {24'd0, exp_w[i]});
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, "_incons_held"}, {31'd0, inconsistent}, {31'd0, exp_incons});
    check({tag, "_rows"}, {28'd0, faulty_row_count}, STATS ? exp_rows : 0);
    check({tag, "_pes"}, {25'd0, faulty_pe_count}, STATS ? exp_pes : 0);
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    start = 1'b0;
    link.map_ready = 1'b1;
    link.row_fault_detection = 1'b0;
    link.single_pe_detection = 1'b0;
    link.column_fault_detection = '0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;

    // all-clean array
    clear_tables();
    run("clean", 25, 1'b0, 0, 0);

    // one single-PE fault on row 3, column 4
    clear_tables();
    rf[3] = 1'b1; sp[3] = 1'b1; col[3] = 8'h10; exp_w[3] = 8'h10;
    run("single", 25, 1'b0, 1, 1);

    // mixed decode cases, including an empty column vector (inconsistent)
    clear_tables();
    rf[1] = 1'b1; sp[1] = 1'b1; col[1] = 8'h81; exp_w[1] = 8'h81;
    rf[2] = 1'b0; sp[2] = 1'b1; col[2] = 8'h55; exp_w[2] = 8'h00;
    rf[3] = 1'b1; sp[3] = 1'b1; col[3] = 8'h10; exp_w[3] = 8'h10;
    rf[5] = 1'b1; sp[5] = 1'b0; col[5] = 8'h24; exp_w[5] = 8'hFF;
    rf[6] = 1'b1; sp[6] = 1'b1; col[6] = 8'h00; exp_w[6] = 8'hFF;
    run("mixed", 25, 1'b1, 4, 19);

    // eNVM stalls row 2 for 4 cycles; start also clears the sticky flag
    clear_tables();
    rf[2] = 1'b1; sp[2] = 1'b1; col[2] = 8'h02; exp_w[2] = 8'h02;
    stall_row = 2; stall_len = 4;
    run("stall", 29, 1'b0, 1, 1);

    // start pulsed again during row 1 REQ must be ignored
    clear_tables();
    rf[7] = 1'b1; sp[7] = 1'b0; col[7] = 8'h01; exp_w[7] = 8'hFF;
    mid_start_cyc = 4;
    run("restart_ignored", 25, 1'b0, 1, 8);

    // reset during row 4 WAIT, then a fresh collection from row 0
    clear_tables();
    rf[4] = 1'b1; sp[4] = 1'b1; col[4] = 8'h00;
    found = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (link.detection_en) begin
        link.row_fault_detection    = rf[link.detection_addr];
        link.single_pe_detection    = sp[link.detection_addr];
        link.column_fault_detection = col[link.detection_addr];
        if (link.detection_addr == 3'd4) found = 1'b1;
      end
    end
    check("rst_reach_row4", {31'd0, found}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("midrst");
    rst = 1'b0;
    clear_tables();
    run("after_rst", 25, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
